cpu_controller: RTL and testbench
=================================

CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 SHALL have ports: clk in 1 (all state changes on rising edge); rst_n in 1 (asynchronous, active-low reset).
REQ-002 SHALL have: opcode in 3 (IR[15:13]); op in 2 (IR[12:11]).
REQ-003 SHALL have: reset_pc out 1 (PC source = start_pc); load_pc out 1; addr_sel out 1 (1=PC, 0=data address register); load_ir out 1; load_addr out 1.
REQ-004 SHALL have: mem_cmd out 2 (00 none, 01 read, 10 write); nsel out 3 (one-hot: 100 Rn, 010 Rd, 001 Rm, 000 none); vsel out 2 (00 C, 01 sximm8, 10 mem data).
REQ-005 SHALL have: write out 1; loada, loadb, loadc, loads out 1 each; asel out 1 (1 = A operand forced 0); bsel out 1 (1 = B operand sximm5); halted out 1.

Function
REQ-006 SHALL be a Moore FSM; every output is decoded from the current state only, and an unlisted output is 0 in a state.
REQ-007 SHALL implement states RST, IF1, IF2, UPC, DEC, WIMM, GA, GB, ALU, WRC, CMPS, ADDR, LADDR, MRD, WMEM, GBD, PASS, STOR, HALT.
REQ-008 RST: reset_pc=1, load_pc=1; next IF1.
REQ-009 IF1: addr_sel=1, mem_cmd=01. IF2: addr_sel=1, mem_cmd=01, load_ir=1. UPC: load_pc=1 (PC+1). DEC: no outputs. Fetch overhead is 4 cycles (IF1, IF2, UPC, DEC).
REQ-010 Decode from DEC, keyed by {opcode,op}; execute-state counts exclude fetch:
- 110_10 MOV imm: WIMM (nsel=100, vsel=01, write=1) -> IF1; 1 cycle.
- 110_00 MOV reg: GB -> ALU -> WRC; 3 cycles.
- 101_00 ADD and 101_10 AND: GA -> GB -> ALU -> WRC; 4 cycles.
- 101_01 CMP: GA -> GB -> CMPS; 3 cycles.
- 101_11 MVN: GB -> ALU -> WRC; 3 cycles.
- 011_00 LDR: GA -> ADDR -> LADDR -> MRD -> WMEM; 5 cycles.
- 100_00 STR: GA -> ADDR -> LADDR -> GBD -> PASS -> STOR; 6 cycles.
- 111_00 HALT: HALT.
- Any other encoding: HALT.
REQ-011 Execute-state outputs:
- GA: nsel=100, loada=1.
- GB: nsel=001, loadb=1.
- GBD: nsel=010, loadb=1.
- ALU: loadc=1; asel=1 for MOV reg/MVN, else 0; bsel=0.
- WRC: nsel=010, vsel=00, write=1.
- CMPS: loads=1.
- ADDR: bsel=1, loadc=1.
- LADDR: load_addr=1.
- MRD: addr_sel=0, mem_cmd=01.
- WMEM: addr_sel=0, mem_cmd=01, nsel=010, vsel=10, write=1.
- PASS: asel=1, loadc=1.
- STOR: addr_sel=0, mem_cmd=10.
REQ-012 The final execute state of each instruction SHALL transition to IF1 on the next edge.
REQ-013 HALT: halted=1, all other outputs 0; remains in HALT until rst_n is asserted.
REQ-014 write and mem_cmd=10 SHALL never be asserted in the same state; mem_cmd=10 SHALL appear only in STOR.

Reset
REQ-015 rst_n=0 SHALL force state RST immediately, independent of clk, including mid-instruction; an interrupted write or store SHALL NOT complete.
REQ-016 While rst_n=0: reset_pc=1, load_pc=1, all other outputs 0; the first rising edge after deassertion SHALL move the FSM to IF1.

Verification
REQ-017 Release reset with IR=110_10 -> IF1, IF2, UPC, DEC, WIMM with the REQ-009/REQ-011 outputs per cycle; IF1 again 5 cycles after leaving RST.
REQ-018 ADD (101_00) -> exactly 8 cycles IF1..WRC; write=1 only in WRC with nsel=010; loada in GA, loadb in GB.
REQ-019 CMP (101_01) -> loads=1 for exactly 1 cycle and write never asserted; 7 cycles total.
REQ-020 LDR then STR -> LDR: mem_cmd=01 with addr_sel=0 in MRD and WMEM, write+vsel=10 in WMEM, 9 cycles. STR: mem_cmd=10 only in STOR, 10 cycles.
REQ-021 HALT (111_00) and illegal 000_00 -> halted=1 held for at least 20 cycles; rst_n pulse returns the FSM to RST, then IF1.
REQ-022 Assert rst_n=0 asynchronously during STR GBD -> outputs equal REQ-016 values before the next clk edge; no mem_cmd=10 observed.

Source files
------------

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - Moore FSM sequencing fetch, decode and execute for a 16-bit CPU datapath
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   opcode[2:0], op[1:0]  instruction fields IR[15:13] and IR[12:11]
//   reset_pc, load_pc     PC source select (start_pc) and PC load enable
//   addr_sel              memory address source: 1 = PC, 0 = data address register
//   load_ir, load_addr    instruction register and data address register loads
//   mem_cmd[1:0]          00 none, 01 read, 10 write
//   nsel[2:0]             register select, one-hot: 100 Rn, 010 Rd, 001 Rm
//   vsel[1:0]             register write-back source: 00 C, 01 sximm8, 10 mem data
//   write                 register file write enable
//   loada..loads          A, B, C and status register loads
//   asel, bsel            A operand forced to 0; B operand taken from sximm5
//   halted                FSM is parked in HALT
module cpu_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       reset_pc,
  output logic       load_pc,
  output logic       addr_sel,
  output logic       load_ir,
  output logic       load_addr,
  output logic [1:0] mem_cmd,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       halted
);

  localparam logic [4:0] S_RST   = 5'd0;
  localparam logic [4:0] S_IF1   = 5'd1;
  localparam logic [4:0] S_IF2   = 5'd2;
  localparam logic [4:0] S_UPC   = 5'd3;
  localparam logic [4:0] S_DEC   = 5'd4;
  localparam logic [4:0] S_WIMM  = 5'd5;
  localparam logic [4:0] S_GA    = 5'd6;
  localparam logic [4:0] S_GB    = 5'd7;
  // ALU is split in two encodings so asel stays a pure function of state:
  // S_ALU for two-operand ops, S_ALU_U for MOV reg / MVN (A forced to 0).
  localparam logic [4:0] S_ALU   = 5'd8;
  localparam logic [4:0] S_ALU_U = 5'd9;
  localparam logic [4:0] S_WRC   = 5'd10;
  localparam logic [4:0] S_CMPS  = 5'd11;
  localparam logic [4:0] S_ADDR  = 5'd12;
  localparam logic [4:0] S_LADDR = 5'd13;
  localparam logic [4:0] S_MRD   = 5'd14;
  localparam logic [4:0] S_WMEM  = 5'd15;
  localparam logic [4:0] S_GBD   = 5'd16;
  localparam logic [4:0] S_PASS  = 5'd17;
  localparam logic [4:0] S_STOR  = 5'd18;
  localparam logic [4:0] S_HALT  = 5'd19;

  localparam logic [4:0] K_MOVI = 5'b110_10;
  localparam logic [4:0] K_MOVR = 5'b110_00;
  localparam logic [4:0] K_ADD  = 5'b101_00;
  localparam logic [4:0] K_CMP  = 5'b101_01;
  localparam logic [4:0] K_AND  = 5'b101_10;
  localparam logic [4:0] K_MVN  = 5'b101_11;
  localparam logic [4:0] K_LDR  = 5'b011_00;
  localparam logic [4:0] K_STR  = 5'b100_00;

  logic [4:0] state;
  logic [4:0] next_state;
  logic [4:0] key;

  // IR is loaded in IF2, so key is stable from DEC to the end of execute.
  assign key = {opcode, op};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RST;
    else        state <= next_state;
  end

  always_comb begin
    next_state = S_HALT;
    case (state)
      S_RST:   next_state = S_IF1;
      S_IF1:   next_state = S_IF2;
      S_IF2:   next_state = S_UPC;
      S_UPC:   next_state = S_DEC;
      S_DEC: begin
        case (key)
          K_MOVI:                      next_state = S_WIMM;
          K_MOVR, K_MVN:               next_state = S_GB;
          K_ADD, K_AND, K_CMP:         next_state = S_GA;
          K_LDR, K_STR:                next_state = S_GA;
          default:                     next_state = S_HALT;
        endcase
      end
      S_GA:    next_state = (key == K_LDR || key == K_STR) ? S_ADDR : S_GB;
      S_GB: begin
        if (key == K_CMP)                      next_state = S_CMPS;
        else if (key == K_ADD || key == K_AND) next_state = S_ALU;
        else                                   next_state = S_ALU_U;
      end
      S_ALU, S_ALU_U: next_state = S_WRC;
      S_ADDR:  next_state = S_LADDR;
      S_LADDR: next_state = (key == K_LDR) ? S_MRD : S_GBD;
      S_MRD:   next_state = S_WMEM;
      S_GBD:   next_state = S_PASS;
      S_PASS:  next_state = S_STOR;
      S_WIMM, S_WRC, S_CMPS, S_WMEM, S_STOR: next_state = S_IF1;
      S_HALT:  next_state = S_HALT;
      default: next_state = S_HALT;
    endcase
  end

  always_comb begin
    reset_pc  = 1'b0;
    load_pc   = 1'b0;
    addr_sel  = 1'b0;
    load_ir   = 1'b0;
    load_addr = 1'b0;
    mem_cmd   = 2'b00;
    nsel      = 3'b000;
    vsel      = 2'b00;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    halted    = 1'b0;
    case (state)
      S_RST:   begin reset_pc = 1'b1; load_pc = 1'b1; end
      S_IF1:   begin addr_sel = 1'b1; mem_cmd = 2'b01; end
      S_IF2:   begin addr_sel = 1'b1; mem_cmd = 2'b01; load_ir = 1'b1; end
      S_UPC:   load_pc = 1'b1;
      S_WIMM:  begin nsel = 3'b100; vsel = 2'b01; write = 1'b1; end
      S_GA:    begin nsel = 3'b100; loada = 1'b1; end
      S_GB:    begin nsel = 3'b001; loadb = 1'b1; end
      S_GBD:   begin nsel = 3'b010; loadb = 1'b1; end
      S_ALU:   loadc = 1'b1;
      S_ALU_U: begin loadc = 1'b1; asel = 1'b1; end
      S_WRC:   begin nsel = 3'b010; vsel = 2'b00; write = 1'b1; end
      S_CMPS:  loads = 1'b1;
      S_ADDR:  begin bsel = 1'b1; loadc = 1'b1; end
      S_LADDR: load_addr = 1'b1;
      S_MRD:   begin addr_sel = 1'b0; mem_cmd = 2'b01; end
      S_WMEM:  begin mem_cmd = 2'b01; nsel = 3'b010; vsel = 2'b10; write = 1'b1; end
      S_PASS:  begin asel = 1'b1; loadc = 1'b1; end
      S_STOR:  mem_cmd = 2'b10;
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - randomized self-checking bench for cpu_controller against a micro-step plan model
module tb_cpu_controller;

  typedef struct packed {
    logic       reset_pc;
    logic       load_pc;
    logic       addr_sel;
    logic       load_ir;
    logic       load_addr;
    logic [1:0] mem_cmd;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       halted;
  } ctl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [2:0] opcode = 3'b000;
  logic [1:0] op = 2'b00;
  logic reset_pc, load_pc, addr_sel, load_ir, load_addr;
  logic [1:0] mem_cmd;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic write, loada, loadb, loadc, loads, asel, bsel, halted;

  int checks = 0;
  int errors = 0;
  string plan_q[$];

  always #5 clk = ~clk;

  cpu_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .op(op),
    .reset_pc(reset_pc), .load_pc(load_pc), .addr_sel(addr_sel),
    .load_ir(load_ir), .load_addr(load_addr), .mem_cmd(mem_cmd),
    .nsel(nsel), .vsel(vsel), .write(write), .loada(loada),
    .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel),
    .bsel(bsel), .halted(halted)
  );

  function automatic ctl_t act();
    return {reset_pc, load_pc, addr_sel, load_ir, load_addr, mem_cmd, nsel,
            vsel, write, loada, loadb, loadc, loads, asel, bsel, halted};
  endfunction

  // Expected control word for one named micro-step.
  function automatic ctl_t exp_of(input string st);
    ctl_t c;
    c = '0;
    case (st)
      "RST":   begin c.reset_pc = 1; c.load_pc = 1; end
      "IF1":   begin c.addr_sel = 1; c.mem_cmd = 2'b01; end
      "IF2":   begin c.addr_sel = 1; c.mem_cmd = 2'b01; c.load_ir = 1; end
      "UPC":   c.load_pc = 1;
      "DEC":   ;
      "WIMM":  begin c.nsel = 3'b100; c.vsel = 2'b01; c.write = 1; end
      "GA":    begin c.nsel = 3'b100; c.loada = 1; end
      "GB":    begin c.nsel = 3'b001; c.loadb = 1; end
      "GBD":   begin c.nsel = 3'b010; c.loadb = 1; end
      "ALU":   c.loadc = 1;
      "ALU_Z": begin c.loadc = 1; c.asel = 1; end
      "WRC":   begin c.nsel = 3'b010; c.write = 1; end
      "CMPS":  c.loads = 1;
      "ADDR":  begin c.bsel = 1; c.loadc = 1; end
      "LADDR": c.load_addr = 1;
      "MRD":   c.mem_cmd = 2'b01;
      "WMEM":  begin c.mem_cmd = 2'b01; c.nsel = 3'b010; c.vsel = 2'b10; c.write = 1; end
      "PASS":  begin c.asel = 1; c.loadc = 1; end
      "STOR":  c.mem_cmd = 2'b10;
      "HALT":  c.halted = 1;
      default: c = 'x;
    endcase
    return c;
  endfunction

  // Full per-cycle step list for one instruction, fetch included.
  task automatic build_plan(input logic [2:0] opc, input logic [1:0] o);
    plan_q = {"IF1", "IF2", "UPC", "DEC"};
    case ({opc, o})
      5'b110_10: plan_q = {plan_q, "WIMM"};
      5'b110_00: plan_q = {plan_q, "GB", "ALU_Z", "WRC"};
      5'b101_11: plan_q = {plan_q, "GB", "ALU_Z", "WRC"};
      5'b101_00: plan_q = {plan_q, "GA", "GB", "ALU", "WRC"};
      5'b101_10: plan_q = {plan_q, "GA", "GB", "ALU", "WRC"};
      5'b101_01: plan_q = {plan_q, "GA", "GB", "CMPS"};
      5'b011_00: plan_q = {plan_q, "GA", "ADDR", "LADDR", "MRD", "WMEM"};
      5'b100_00: plan_q = {plan_q, "GA", "ADDR", "LADDR", "GBD", "PASS", "STOR"};
      default:   plan_q = {plan_q, "HALT"};
    endcase
  endtask

  // Checks the first n planned steps, one per clock; entered just after
  // the edge that moved the FSM into IF1.
  task automatic run_plan(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (act() !== exp_of(plan_q[i])) begin
        errors++;
        $display("FAIL %s step %0d (%s): got %h expected %h", name, i, plan_q[i], act(), exp_of(plan_q[i]));
      end
      checks++;
      if (write === 1'b1 && mem_cmd === 2'b10) begin
        errors++;
        $display("FAIL %s step %0d write_with_store: got write=1 mem_cmd=10 expected exclusive", name, i);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(input string name, input logic [2:0] opc, input logic [1:0] o);
    opcode = opc;
    op = o;
    build_plan(opc, o);
    run_plan(name, plan_q.size());
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (act() !== exp_of("RST")) begin
      errors++;
      $display("FAIL %s async_rst: got %h expected %h", name, act(), exp_of("RST"));
    end
    @(negedge clk);
    checks++;
    if (act() !== exp_of("RST")) begin
      errors++;
      $display("FAIL %s held_rst: got %h expected %h", name, act(), exp_of("RST"));
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (act() !== exp_of("RST")) begin
      errors++;
      $display("FAIL reset_initial: got %h expected %h", act(), exp_of("RST"));
    end
    do_reset("reset");
  endtask

  task automatic test_mov_imm();
    run_instr("mov_imm", 3'b110, 2'b10);
    // IF1 must follow WIMM: five cycles after leaving RST.
    @(negedge clk);
    checks++;
    if (act() !== exp_of("IF1")) begin
      errors++;
      $display("FAIL mov_imm_return_if1: got %h expected %h", act(), exp_of("IF1"));
    end
    @(posedge clk);
    #1;
    // that IF1 was consumed; restart cleanly from reset
    do_reset("mov_imm_rst");
  endtask

  task automatic test_alu_ops();
    run_instr("add", 3'b101, 2'b00);
    run_instr("cmp", 3'b101, 2'b01);
    run_instr("and", 3'b101, 2'b10);
    run_instr("mvn", 3'b101, 2'b11);
    run_instr("mov_reg", 3'b110, 2'b00);
  endtask

  task automatic test_ldr_str();
    run_instr("ldr", 3'b011, 2'b00);
    run_instr("str", 3'b100, 2'b00);
  endtask

  task automatic test_random();
    logic [4:0] legal [8];
    logic [4:0] k;
    legal = '{5'b110_10, 5'b110_00, 5'b101_00, 5'b101_01,
              5'b101_10, 5'b101_11, 5'b011_00, 5'b100_00};
    for (int i = 0; i < 40; i++) begin
      k = legal[$urandom_range(0, 7)];
      run_instr($sformatf("rand%0d_%b", i, k), k[4:2], k[1:0]);
    end
  endtask

  task automatic check_halted(input string name);
    for (int i = 0; i < 20; i++) begin
      opcode = 3'($urandom);
      op = 2'($urandom);
      @(negedge clk);
      checks++;
      if (act() !== exp_of("HALT")) begin
        errors++;
        $display("FAIL %s hold %0d: got %h expected %h", name, i, act(), exp_of("HALT"));
      end
    end
    do_reset(name);
  endtask

  task automatic test_halt();
    logic [4:0] k;
    run_instr("halt", 3'b111, 2'b00);
    check_halted("halt");
    run_instr("illegal_000", 3'b000, 2'b00);
    check_halted("illegal_000");
    for (int i = 0; i < 3; i++) begin
      do begin
        k = 5'($urandom);
      end while (k inside {5'b110_10, 5'b110_00, 5'b101_00, 5'b101_01,
                           5'b101_10, 5'b101_11, 5'b011_00, 5'b100_00});
      run_instr($sformatf("illegal_%b", k), k[4:2], k[1:0]);
      check_halted("illegal_rand");
    end
    run_instr("after_halt_mov", 3'b110, 2'b10);
  endtask

  task automatic test_mid_reset();
    bit stored;
    opcode = 3'b100;
    op = 2'b00;
    build_plan(3'b100, 2'b00);
    // Run through LADDR; FSM is now in GBD.
    run_plan("str_mid", 7);
    checks++;
    if (act() !== exp_of("GBD")) begin
      errors++;
      $display("FAIL str_mid_gbd: got %h expected %h", act(), exp_of("GBD"));
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (act() !== exp_of("RST")) begin
      errors++;
      $display("FAIL str_mid_async: got %h expected %h", act(), exp_of("RST"));
    end
    stored = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_cmd === 2'b10) stored = 1'b1;
    end
    checks++;
    if (stored) begin
      errors++;
      $display("FAIL str_mid_no_store: got mem_cmd=10 expected none");
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_instr("after_mid_reset_add", 3'b101, 2'b00);
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_alu_ops();
    test_ldr_str();
    test_random();
    test_mid_reset();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
